fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Front-end producer of the instruction stream consumed by the NOP-select / hazard logic and the decode stage. It generates icache fetch addresses and tracks the PC of the instruction currently on icache_dout. It applies redirects from branch/JALR resolution and squashes stale wrong-path fetches. It also registers prev_inst, the previously issued instruction, for NOP selection. Sits between PC reset/redirect sources and the icache/decode boundary.

Parameters:
RESET_PC, 32'h4000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, canonical bubble (addi x0,x0,0; opcode = OPC_NOOP class)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  global pipeline stall (cache miss); freezes all state except redirect capture
redirect_valid  in  1  branch taken / JALR resolved this cycle
redirect_pc  in  32  target of redirect; bits [1:0] ignored (forced 0)
nop_sel  in  1  NOPSignal from NOP-select logic: replace current instruction with bubble
icache_addr  out  32  fetch address, read data returned next unstalled cycle
icache_re  out  1  read enable
icache_dout  in  32  instruction for address presented in previous unstalled cycle
inst_out  out  32  instruction issued to decode (icache_dout or NOP_INST)
pc_out  out  32  PC of inst_out
inst_valid  out  1  1 when inst_out is a real fetched instruction
prev_inst  out  32  last issued inst_out, to NOP-select logic
bubble_count  out  16  saturating count of injected bubbles

Behaviour:
- Reset is asynchronous on rst_n low. Outputs during and after reset: icache_addr=RESET_PC, icache_re=1, pc_out=RESET_PC, prev_inst=NOP_INST, inst_valid=0, bubble_count=0, state=BOOT, no pending redirect.
- Icache latency is 1 cycle: the address presented in unstalled cycle N yields icache_dout in cycle N+1. pc_out is the registered copy of icache_addr.
- FSM states:
  - BOOT: first cycle after reset; dout is invalid, so a bubble is issued. Moves to RUN on !stall.
  - RUN: normal fetch.
  - SQUASH: dout belongs to the wrong path, so a bubble is issued. Moves to RUN on !stall.
- Next-address priority:
  - rst_n low.
  - Effective redirect (redirect_valid, or pending redirect with !stall): icache_addr←target, go to SQUASH.
  - stall: hold all.
  - Otherwise icache_addr←icache_addr+4, with 32-bit wrap (32'hFFFF_FFFC+4 → 0).
- Redirect during stall: the target is latched into a pending register. A later redirect during the same stall overwrites it. The pending redirect is applied in the first cycle with stall=0, and pending is then cleared.
- Redirect with !stall is applied the same cycle; the same-cycle nop_sel is irrelevant because a bubble is issued.
- Issue, combinational on current state: bubble = (state≠RUN) | nop_sel | redirect_taken_this_cycle.
  - inst_out = bubble ? NOP_INST : icache_dout.
  - inst_valid = !bubble & !stall.
- nop_sel in RUN without redirect: this is a hazard hold. icache_addr and pc_out hold for one cycle so the killed instruction is re-fetched. Exception: when the prior issued instruction was a branch, the PC is not held; the dropped fall-through is superseded by the pending redirect.
  - prev_inst opcode is OPC_BRANCH: advance normally.
  - Otherwise: hold PC.
- prev_inst ← inst_out on each !stall edge, bubbles included.
- bubble_count increments on each !stall edge where bubble=1 and saturates at 16'hFFFF.
- icache_re = !stall.

Decomposition:
- Shared Opcode.vh holds OPC_* constants (OPC_BRANCH, OPC_JALR, OPC_NOOP), plus NOP_INST and the RESET_PC default.
- FSM state encodings (BOOT/RUN/SQUASH) are localparams in the module.
- One natural sub-module is fetch_next_pc: a combinational priority mux for redirect/pending/hold/+4. Everything else stays in fetch_sequencer.

Test Plan:
1. Reset then run: release rst_n with stall=0 → cycle 0 inst_valid=0, inst_out=32'h13. Subsequent pc_out sequence is 4000_0000, 4000_0004, 4000_0008, with inst_out equal to icache_dout.
2. Redirect: redirect_valid=1, redirect_pc=32'h4000_0103 at pc_out=4000_0008 → next icache_addr=4000_0100. One SQUASH bubble follows, then inst_valid=1 at pc_out=4000_0100. bubble_count +2 (redirect cycle + squash).
3. Redirect during stall: stall=1 for 3 cycles, with redirect to 4000_0200 then 4000_0300 inside the stall → addresses frozen during stall. First unstalled cycle sets icache_addr=4000_0300 and enters SQUASH; 4000_0200 is never fetched.
4. JALR hazard: nop_sel=1 for one cycle with prev_inst a non-branch → inst_out=32'h13 and the same pc_out is re-presented next cycle with inst_valid=1. prev_inst=32'h13 after the bubble.
5. Async reset mid-stream: rst_n low between edges while in SQUASH with a pending redirect → outputs return to reset values immediately and the pending redirect is discarded.
6. Wrap and saturation: preload icache_addr=FFFF_FFFC via redirect → next address is 0000_0000. Holding nop_sel=1 for 70000 cycles → bubble_count=16'hFFFF.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants for the fetch front end.
//   OPC_*         : RISC-V major opcodes the fetch/NOP-select logic cares about
//   NOP_INST_DEF  : canonical bubble, addi x0,x0,0
//   RESET_PC_DEF  : default first fetch address after reset
package fetch_sequencer_pkg;

  localparam logic [6:0]  OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0]  OPC_JALR     = 7'b1100111;
  localparam logic [6:0]  OPC_NOOP     = 7'b0010011;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h4000_0000;

  function automatic logic is_branch(input logic [31:0] inst);
    return inst[6:0] == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// Next fetch address priority mux.
//   i_cur_addr  : address currently presented to the icache
//   i_redirect  : a redirect is being applied this cycle
//   i_target    : word-aligned redirect target
//   i_stall     : pipeline stall, freezes the address
//   i_hold      : hazard hold, re-present the current address
//   o_next_addr : address to present next cycle
module fetch_sequencer_next_pc (
  input  logic [31:0] i_cur_addr,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  input  logic        i_stall,
  input  logic        i_hold,
  output logic [31:0] o_next_addr
);

  always_comb begin
    o_next_addr = i_cur_addr + 32'd4;  // wraps naturally at 2^32
    if (i_redirect) begin
      o_next_addr = i_target;
    end else if (i_stall || i_hold) begin
      o_next_addr = i_cur_addr;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives icache fetch addresses, tracks the PC of the
// instruction on icache_dout, applies (possibly stall-deferred) redirects and issues
// either the fetched instruction or a bubble to decode.
//   clk, rst_n         : clock, asynchronous active-low reset
//   stall              : global stall; only redirect capture proceeds
//   redirect_valid/_pc : branch/JALR redirect, target bits [1:0] ignored
//   nop_sel            : replace the current instruction with a bubble
//   icache_addr/_re    : fetch request, data returns the next unstalled cycle
//   icache_dout        : instruction for the previously presented address
//   inst_out/pc_out    : issued instruction and its PC
//   inst_valid         : inst_out is a real fetched instruction
//   prev_inst          : last issued instruction, for NOP selection
//   bubble_count       : saturating count of issued bubbles
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        nop_sel,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid,
  output logic [31:0] prev_inst,
  output logic [15:0] bubble_count
);

  typedef enum logic [1:0] {StBoot, StRun, StSquash} state_e;

  state_e      r_state, w_state_next;
  logic [31:0] r_addr, r_pc, r_prev, r_pend_pc;
  logic        r_pend_valid;
  logic [15:0] r_bcnt;

  logic        w_redir_take, w_hold, w_bubble, w_pc_adv;
  logic [31:0] w_redir_pc, w_addr_next, w_inst;

  // A fresh redirect supersedes one captured earlier in the stall.
  assign w_redir_take = !stall && (redirect_valid || r_pend_valid);
  assign w_redir_pc   = redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : r_pend_pc;

  // Hazard hold re-presents the PC, unless the previous instruction was a branch:
  // its redirect will supersede the dropped fall-through anyway.
  assign w_hold   = (r_state == StRun) && nop_sel && !is_branch(r_prev);
  assign w_bubble = (r_state != StRun) || nop_sel || w_redir_take;
  assign w_pc_adv = !stall && (w_redir_take || !w_hold);

  fetch_sequencer_next_pc u_next_pc (
    .i_cur_addr  (r_addr),
    .i_redirect  (w_redir_take),
    .i_target    (w_redir_pc),
    .i_stall     (stall),
    .i_hold      (w_hold),
    .o_next_addr (w_addr_next)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StBoot;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (w_redir_take) begin
      w_state_next = StSquash;
    end else if (!stall) begin
      w_state_next = StRun;
    end
  end

  // Output logic
  always_comb begin
    w_inst     = w_bubble ? NOP_INST : icache_dout;
    inst_out   = w_inst;
    inst_valid = !w_bubble && !stall;
    icache_re  = !stall;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= RESET_PC;
      r_pc         <= RESET_PC;
      r_prev       <= NOP_INST;
      r_bcnt       <= 16'd0;
      r_pend_valid <= 1'b0;
      r_pend_pc    <= 32'd0;
    end else begin
      r_addr <= w_addr_next;
      if (w_pc_adv) begin
        r_pc <= r_addr;
      end
      if (!stall) begin
        r_prev <= w_inst;
        if (w_bubble && (r_bcnt != 16'hFFFF)) begin
          r_bcnt <= r_bcnt + 16'd1;
        end
      end
      if (w_redir_take) begin
        r_pend_valid <= 1'b0;
      end else if (stall && redirect_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_pc    <= redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  assign icache_addr  = r_addr;
  assign pc_out       = r_pc;
  assign prev_inst    = r_prev;
  assign bubble_count = r_bcnt;

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  localparam logic [31:0] RST_PC = 32'h4000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, nop_sel;
  logic [31:0] redirect_pc, icache_dout;
  logic [31:0] icache_addr, inst_out, pc_out, prev_inst;
  logic        icache_re, inst_valid;
  logic [15:0] bubble_count;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .nop_sel        (nop_sel),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .inst_valid     (inst_valid),
    .prev_inst      (prev_inst),
    .bubble_count   (bubble_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: mode 0 = boot, 1 = normal, 2 = squash.
  int          m_mode;
  logic [31:0] m_addr, m_pc, m_prev, m_pend_pc, m_fetched;
  logic        m_pend, m_fvalid;
  int          m_cnt;

  // Synthetic instruction memory; about a quarter of words are branches.
  function automatic logic [31:0] imem(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    h  = a * 32'h9E37_79B1 + 32'h1234_5677;
    op = (h[31:30] == 2'b00) ? 7'b1100011 : (h[29] ? 7'b0010011 : 7'b0110011);
    return {h[24:0], op};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_addr = RST_PC; m_pc = RST_PC; m_prev = NOP;
    m_pend = 1'b0; m_pend_pc = 32'd0; m_cnt = 0; m_fvalid = 1'b0; m_fetched = 32'd0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare #1 later, step model at posedge.
  task automatic cyc(input logic st, input logic rv, input logic [31:0] rpc, input logic ns);
    logic        take, bub;
    logic [31:0] tgt, exp_inst;
    stall = st; redirect_valid = rv; redirect_pc = rpc; nop_sel = ns;
    icache_dout = m_fvalid ? imem(m_fetched) : 32'hDEAD_BEEF;
    take     = !st && (rv || m_pend);
    tgt      = rv ? {rpc[31:2], 2'b00} : m_pend_pc;
    bub      = (m_mode != 1) || ns || take;
    exp_inst = bub ? NOP : icache_dout;
    #1;
    chk("icache_addr",  icache_addr, m_addr);
    chk("icache_re",    {31'd0, icache_re}, {31'd0, !st});
    chk("pc_out",       pc_out, m_pc);
    chk("inst_out",     inst_out, exp_inst);
    chk("inst_valid",   {31'd0, inst_valid}, {31'd0, !bub && !st});
    chk("prev_inst",    prev_inst, m_prev);
    chk("bubble_count", {16'd0, bubble_count}, m_cnt);
    @(posedge clk);
    if (!st) begin
      m_fetched = m_addr;
      m_fvalid  = 1'b1;
      if (bub && m_cnt < 65535) m_cnt++;
    end
    if (take) begin
      m_pc = m_addr; m_addr = tgt; m_mode = 2; m_pend = 1'b0;
    end else if (st) begin
      if (rv) begin
        m_pend = 1'b1; m_pend_pc = {rpc[31:2], 2'b00};
      end
    end else if (m_mode == 1 && ns && m_prev[6:0] != 7'b1100011) begin
      // hazard hold: address and PC stay put
    end else begin
      m_pc = m_addr; m_addr = m_addr + 32'd4; m_mode = 1;
    end
    if (!st) m_prev = exp_inst;
    @(negedge clk);
  endtask

  task automatic peek_idle();
    stall = 1'b0; redirect_valid = 1'b0; nop_sel = 1'b0;
    icache_dout = m_fvalid ? imem(m_fetched) : 32'hDEAD_BEEF;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    nop_sel = 1'b0; icache_dout = 32'd0;
    model_reset();
    @(negedge clk);
    // Reset values
    chk("rst icache_addr", icache_addr, RST_PC);
    chk("rst pc_out", pc_out, RST_PC);
    chk("rst prev_inst", prev_inst, NOP);
    chk("rst bubble_count", {16'd0, bubble_count}, 32'd0);
    chk("rst icache_re", {31'd0, icache_re}, 32'd1);
    rst_n = 1'b1;

    // 1. Boot bubble then sequential fetch
    peek_idle();
    chk("boot inst_out", inst_out, NOP);
    chk("boot inst_valid", {31'd0, inst_valid}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("run pc0", pc_out, 32'h4000_0000);
    cyc(0, 0, 0, 0);
    chk("run pc1", pc_out, 32'h4000_0004);
    cyc(0, 0, 0, 0);
    chk("run pc2", pc_out, 32'h4000_0008);
    chk("run bcnt", {16'd0, bubble_count}, 32'd1);

    // 2. Redirect with misaligned target
    cyc(0, 1, 32'h4000_0103, 0);
    chk("redir addr", icache_addr, 32'h4000_0100);
    cyc(0, 0, 0, 0);
    chk("redir pc", pc_out, 32'h4000_0100);
    peek_idle();
    chk("redir valid", {31'd0, inst_valid}, 32'd1);
    chk("redir bcnt", {16'd0, bubble_count}, 32'd3);

    // 3. Redirects captured during a stall; the later one wins
    cyc(1, 1, 32'h4000_0200, 0);
    chk("stall addr a", icache_addr, 32'h4000_0104);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 32'h4000_0300, 0);
    chk("stall addr b", icache_addr, 32'h4000_0104);
    chk("stall pc", pc_out, 32'h4000_0100);
    cyc(0, 0, 0, 0);
    chk("pend addr", icache_addr, 32'h4000_0300);
    chk("pend bcnt", {16'd0, bubble_count}, 32'd4);
    cyc(0, 0, 0, 0);
    chk("pend pc", pc_out, 32'h4000_0300);
    chk("squash prev", prev_inst, NOP);

    // 4. Hazard hold with a non-branch previous instruction
    cyc(0, 0, 0, 1);
    chk("hold pc", pc_out, 32'h4000_0300);
    chk("hold addr", icache_addr, 32'h4000_0304);
    chk("hold prev", prev_inst, NOP);
    peek_idle();
    chk("hold valid", {31'd0, inst_valid}, 32'd1);
    cyc(0, 0, 0, 0);
    chk("after hold pc", pc_out, 32'h4000_0304);

    // 5. Async reset in squash with a pending redirect
    cyc(0, 1, 32'h4000_0400, 0);
    cyc(1, 1, 32'h4000_0500, 0);
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    #1;
    model_reset();
    chk("arst addr", icache_addr, RST_PC);
    chk("arst pc", pc_out, RST_PC);
    chk("arst prev", prev_inst, NOP);
    chk("arst bcnt", {16'd0, bubble_count}, 32'd0);
    chk("arst valid", {31'd0, inst_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("arst no pend", pc_out, 32'h4000_0004);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic        st, rv, ns;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 3) == 0);
      rv  = ($urandom_range(0, 9) == 0);
      ns  = ($urandom_range(0, 6) == 0);
      rpc = 32'h4000_0000 | ($urandom & 32'h0000_FFFF);
      cyc(st, rv, rpc, ns);
    end

    // 6. Address wrap and bubble counter saturation
    cyc(0, 1, 32'hFFFF_FFFF, 0);
    chk("wrap addr0", icache_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap addr1", icache_addr, 32'h0000_0000);
    chk("wrap pc", pc_out, 32'hFFFF_FFFC);
    for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 1);
    chk("sat bcnt", {16'd0, bubble_count}, 32'h0000_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
